// File: rtl/csr_pkg.sv
// Shared CSR addresses, Zicsr op codes and mstatus bit positions for the CSR file.
package csr_pkg;

    localparam int unsigned CSR_XLEN   = 32;
    localparam int unsigned CSR_ADDR_W = 12;
    localparam int unsigned FFLAGS_W   = 5;
    localparam int unsigned FRM_W      = 3;
    localparam int unsigned CNT_W      = 64;

    localparam logic [CSR_ADDR_W-1:0] CSR_FFLAGS    = 12'h001;
    localparam logic [CSR_ADDR_W-1:0] CSR_FRM       = 12'h002;
    localparam logic [CSR_ADDR_W-1:0] CSR_FCSR      = 12'h003;
    localparam logic [CSR_ADDR_W-1:0] CSR_MSTATUS   = 12'h300;
    localparam logic [CSR_ADDR_W-1:0] CSR_MTVEC     = 12'h305;
    localparam logic [CSR_ADDR_W-1:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [CSR_ADDR_W-1:0] CSR_MEPC      = 12'h341;
    localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE    = 12'h342;
    localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [CSR_ADDR_W-1:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [CSR_ADDR_W-1:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [CSR_ADDR_W-1:0] CSR_CYCLE     = 12'hC00;
    localparam logic [CSR_ADDR_W-1:0] CSR_INSTRET   = 12'hC02;
    localparam logic [CSR_ADDR_W-1:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [CSR_ADDR_W-1:0] CSR_INSTRETH  = 12'hC82;

    localparam logic [2:0] CSR_RW  = 3'b001;
    localparam logic [2:0] CSR_RS  = 3'b010;
    localparam logic [2:0] CSR_RC  = 3'b011;
    localparam logic [2:0] CSR_RWI = 3'b101;
    localparam logic [2:0] CSR_RSI = 3'b110;
    localparam logic [2:0] CSR_RCI = 3'b111;

    localparam int unsigned MIE_BIT  = 3;
    localparam int unsigned MPIE_BIT = 7;

    // Low two funct3 bits select write/set/clear for both register and immediate forms.
    function automatic logic [CSR_XLEN-1:0] csr_apply(
        input logic [1:0]          kind,
        input logic [CSR_XLEN-1:0] old_val,
        input logic [CSR_XLEN-1:0] src
    );
        logic [CSR_XLEN-1:0] res;
        case (kind)
            2'b01:   res = src;
            2'b10:   res = old_val | src;
            2'b11:   res = old_val & ~src;
            default: res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free counter with independent half-word overwrite; a write suppresses that cycle's increment.
module csr_counter64
    import csr_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc,
    input  logic                wr_lo,
    input  logic                wr_hi,
    input  logic [CSR_XLEN-1:0] wdata,
    output logic [CNT_W-1:0]    count
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo || wr_hi) begin
            if (wr_lo) cnt_d[CSR_XLEN-1:0]     = wdata;
            if (wr_hi) cnt_d[CNT_W-1:CSR_XLEN] = wdata;
        end else if (inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign count = cnt_q;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode and F-extension CSR file: Zicsr read/modify/write, counters, fflags accrual, trap/mret state.
module csr_unit
    import csr_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  csr_en,
    input  logic [2:0]            csr_op,
    input  logic [CSR_ADDR_W-1:0] csr_addr,
    input  logic [XLEN-1:0]       csr_src,
    input  logic                  csr_src_nz,
    output logic [XLEN-1:0]       csr_rdata,
    output logic                  csr_illegal,
    input  logic                  instr_ret,
    input  logic                  fflags_valid,
    input  logic [FFLAGS_W-1:0]   fflags_in,
    output logic [FRM_W-1:0]      frm_out,
    input  logic                  trap_req,
    input  logic [XLEN-1:0]       trap_pc,
    input  logic [XLEN-1:0]       trap_cause,
    input  logic                  mret,
    output logic [XLEN-1:0]       mtvec_out,
    output logic [XLEN-1:0]       mepc_out
);

    logic [FFLAGS_W-1:0] fflags_q,   fflags_d;
    logic [FRM_W-1:0]    frm_q,      frm_d;
    logic                mie_q,      mie_d;
    logic                mpie_q,     mpie_d;
    logic [XLEN-1:0]     mtvec_q,    mtvec_d;
    logic [XLEN-1:0]     mscratch_q, mscratch_d;
    logic [XLEN-1:0]     mepc_q,     mepc_d;
    logic [XLEN-1:0]     mcause_q,   mcause_d;

    logic [CNT_W-1:0]    mcycle;
    logic [CNT_W-1:0]    minstret;

    logic [XLEN-1:0]     rd_val;
    logic [XLEN-1:0]     mstatus_rd;
    logic [XLEN-1:0]     wdata;
    logic                mapped;
    logic                op_ok;
    logic                wr_intent;
    logic                illegal_c;
    logic                wr_en;

    // Address decode and read mux.
    always_comb begin
        mstatus_rd           = '0;
        mstatus_rd[MIE_BIT]  = mie_q;
        mstatus_rd[MPIE_BIT] = mpie_q;
        mapped = 1'b1;
        rd_val = '0;
        case (csr_addr)
            CSR_FFLAGS:                 rd_val = XLEN'(fflags_q);
            CSR_FRM:                    rd_val = XLEN'(frm_q);
            CSR_FCSR:                   rd_val = XLEN'({frm_q, fflags_q});
            CSR_MSTATUS:                rd_val = mstatus_rd;
            CSR_MTVEC:                  rd_val = mtvec_q;
            CSR_MSCRATCH:               rd_val = mscratch_q;
            CSR_MEPC:                   rd_val = mepc_q;
            CSR_MCAUSE:                 rd_val = mcause_q;
            CSR_MCYCLE,   CSR_CYCLE:    rd_val = mcycle[XLEN-1:0];
            CSR_MCYCLEH,  CSR_CYCLEH:   rd_val = mcycle[CNT_W-1:XLEN];
            CSR_MINSTRET, CSR_INSTRET:  rd_val = minstret[XLEN-1:0];
            CSR_MINSTRETH, CSR_INSTRETH: rd_val = minstret[CNT_W-1:XLEN];
            default:                    mapped = 1'b0;
        endcase
    end

    // Legality and write qualification; set/clear forms with a zero source do not write.
    always_comb begin
        op_ok     = (csr_op == CSR_RW)  || (csr_op == CSR_RS)  || (csr_op == CSR_RC) ||
                    (csr_op == CSR_RWI) || (csr_op == CSR_RSI) || (csr_op == CSR_RCI);
        wr_intent = op_ok && ((csr_op[1:0] == 2'b01) || csr_src_nz);
        illegal_c = csr_en && (!mapped || !op_ok ||
                               ((csr_addr[11:10] == 2'b11) && wr_intent));
        wr_en     = csr_en && !illegal_c && wr_intent && !trap_req;
        wdata     = csr_apply(csr_op[1:0], rd_val, csr_src);
    end

    assign csr_rdata   = csr_en ? rd_val : '0;
    assign csr_illegal = illegal_c;

    // Next-state: FPU accrual first so a same-cycle CSR write overrides it; trap then mret override mstatus.
    always_comb begin
        fflags_d   = fflags_q;
        frm_d      = frm_q;
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;

        if (fflags_valid) fflags_d = fflags_q | fflags_in;

        if (wr_en) begin
            case (csr_addr)
                CSR_FFLAGS:   fflags_d = wdata[FFLAGS_W-1:0];
                CSR_FRM:      frm_d    = wdata[FRM_W-1:0];
                CSR_FCSR:     {frm_d, fflags_d} = wdata[FRM_W+FFLAGS_W-1:0];
                CSR_MSTATUS: begin
                    mie_d  = wdata[MIE_BIT];
                    mpie_d = wdata[MPIE_BIT];
                end
                CSR_MTVEC:    mtvec_d    = wdata & ~XLEN'(3);
                CSR_MSCRATCH: mscratch_d = wdata;
                CSR_MEPC:     mepc_d     = wdata & ~XLEN'(3);
                CSR_MCAUSE:   mcause_d   = wdata;
                default: ;
            endcase
        end

        if (trap_req) begin
            mepc_d   = trap_pc & ~XLEN'(3);
            mcause_d = trap_cause;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fflags_q   <= '0;
            frm_q      <= '0;
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= XLEN'(MTVEC_RESET);
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else begin
            fflags_q   <= fflags_d;
            frm_q      <= frm_d;
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (1'b1),
        .wr_lo (wr_en && (csr_addr == CSR_MCYCLE)),
        .wr_hi (wr_en && (csr_addr == CSR_MCYCLEH)),
        .wdata (wdata),
        .count (mcycle)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (instr_ret),
        .wr_lo (wr_en && (csr_addr == CSR_MINSTRET)),
        .wr_hi (wr_en && (csr_addr == CSR_MINSTRETH)),
        .wdata (wdata),
        .count (minstret)
    );

    assign frm_out   = frm_q;
    assign mtvec_out = mtvec_q;
    assign mepc_out  = mepc_q;

endmodule

// File: tb/tb_csr_unit.sv
// Bench for csr_unit: architectural CSR model checked every cycle plus directed literal checks.
module tb_csr_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        csr_en = 1'b0;
    logic [2:0]  csr_op = 3'b000;
    logic [11:0] csr_addr = 12'h000;
    logic [31:0] csr_src = 32'h0;
    logic        csr_src_nz = 1'b0;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        instr_ret = 1'b0;
    logic        fflags_valid = 1'b0;
    logic [4:0]  fflags_in = 5'h0;
    logic [2:0]  frm_out;
    logic        trap_req = 1'b0;
    logic [31:0] trap_pc = 32'h0;
    logic [31:0] trap_cause = 32'h0;
    logic        mret = 1'b0;
    logic [31:0] mtvec_out;
    logic [31:0] mepc_out;

    always #5 clk = ~clk;

    csr_unit #(.XLEN(32), .MTVEC_RESET(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .csr_en       (csr_en),
        .csr_op       (csr_op),
        .csr_addr     (csr_addr),
        .csr_src      (csr_src),
        .csr_src_nz   (csr_src_nz),
        .csr_rdata    (csr_rdata),
        .csr_illegal  (csr_illegal),
        .instr_ret    (instr_ret),
        .fflags_valid (fflags_valid),
        .fflags_in    (fflags_in),
        .frm_out      (frm_out),
        .trap_req     (trap_req),
        .trap_pc      (trap_pc),
        .trap_cause   (trap_cause),
        .mret         (mret),
        .mtvec_out    (mtvec_out),
        .mepc_out     (mepc_out)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @%0t", name, got, exp, $time);
        end
    endtask

    // Architectural state of the model.
    logic [4:0]  m_fflags;
    logic [2:0]  m_frm;
    logic        m_mie, m_mpie;
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] m_cyc, m_ins;

    function automatic logic [31:0] m_read(input logic [11:0] a, output bit hit);
        hit = 1'b1;
        case (a)
            12'h001: return {27'd0, m_fflags};
            12'h002: return {29'd0, m_frm};
            12'h003: return {24'd0, m_frm, m_fflags};
            12'h300: return {24'd0, m_mpie, 3'b000, m_mie, 3'b000};
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'hB00, 12'hC00: return m_cyc[31:0];
            12'hB80, 12'hC80: return m_cyc[63:32];
            12'hB02, 12'hC02: return m_ins[31:0];
            12'hB82, 12'hC82: return m_ins[63:32];
            default: begin hit = 1'b0; return 32'h0; end
        endcase
    endfunction

    function automatic bit m_intent(input logic [2:0] op, input logic nz);
        if (op == 3'b001 || op == 3'b101) return 1'b1;
        if (op == 3'b010 || op == 3'b011 || op == 3'b110 || op == 3'b111) return nz;
        return 1'b0;
    endfunction

    function automatic bit m_illegal(input logic [2:0] op, input logic [11:0] a, input logic nz);
        bit hit;
        logic [31:0] dummy;
        dummy = m_read(a, hit);
        if (!hit) return 1'b1;
        if (op == 3'b000 || op == 3'b100) return 1'b1;
        return (a[11:10] == 2'b11) && m_intent(op, nz);
    endfunction

    // Model update at each clock edge from the inputs presented during the preceding cycle.
    always @(posedge clk or negedge rst_n) begin : model_upd
        bit hit;
        bit wr;
        logic [31:0] old_v, new_v;
        logic [63:0] n_cyc, n_ins;
        if (!rst_n) begin
            m_fflags = 5'h0; m_frm = 3'h0; m_mie = 1'b0; m_mpie = 1'b0;
            m_mtvec = 32'h0; m_mscratch = 32'h0; m_mepc = 32'h0; m_mcause = 32'h0;
            m_cyc = 64'h0; m_ins = 64'h0;
        end else begin
            old_v = m_read(csr_addr, hit);
            wr = csr_en && !m_illegal(csr_op, csr_addr, csr_src_nz) &&
                 m_intent(csr_op, csr_src_nz) && !trap_req;
            if (csr_op == 3'b001 || csr_op == 3'b101)      new_v = csr_src;
            else if (csr_op == 3'b010 || csr_op == 3'b110) new_v = old_v | csr_src;
            else                                           new_v = old_v & ~csr_src;
            n_cyc = m_cyc + 64'd1;
            n_ins = instr_ret ? m_ins + 64'd1 : m_ins;
            if (fflags_valid) m_fflags = m_fflags | fflags_in;
            if (wr) begin
                case (csr_addr)
                    12'h001: m_fflags = new_v[4:0];
                    12'h002: m_frm = new_v[2:0];
                    12'h003: begin m_frm = new_v[7:5]; m_fflags = new_v[4:0]; end
                    12'h300: begin m_mie = new_v[3]; m_mpie = new_v[7]; end
                    12'h305: m_mtvec = {new_v[31:2], 2'b00};
                    12'h340: m_mscratch = new_v;
                    12'h341: m_mepc = {new_v[31:2], 2'b00};
                    12'h342: m_mcause = new_v;
                    12'hB00: n_cyc = {m_cyc[63:32], new_v};
                    12'hB80: n_cyc = {new_v, m_cyc[31:0]};
                    12'hB02: n_ins = {m_ins[63:32], new_v};
                    12'hB82: n_ins = {new_v, m_ins[31:0]};
                    default: ;
                endcase
            end
            if (trap_req) begin
                m_mepc = {trap_pc[31:2], 2'b00};
                m_mcause = trap_cause;
                m_mpie = m_mie;
                m_mie = 1'b0;
            end else if (mret) begin
                m_mie = m_mpie;
                m_mpie = 1'b1;
            end
            m_cyc = n_cyc;
            m_ins = n_ins;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin : model_cmp
        bit hit;
        logic [31:0] v;
        if (rst_n) begin
            v = m_read(csr_addr, hit);
            chk("m_rdata", csr_rdata, csr_en ? v : 32'h0);
            chk("m_illegal", {31'd0, csr_illegal},
                {31'd0, csr_en && m_illegal(csr_op, csr_addr, csr_src_nz)});
            chk("m_frm_out", {29'd0, frm_out}, {29'd0, m_frm});
            chk("m_mtvec_out", mtvec_out, m_mtvec);
            chk("m_mepc_out", mepc_out, m_mepc);
        end
    end

    task automatic drive(input logic en, input logic [2:0] op, input logic [11:0] a,
                         input logic [31:0] s, input logic nz);
        @(posedge clk);
        #1;
        csr_en = en; csr_op = op; csr_addr = a; csr_src = s; csr_src_nz = nz;
        instr_ret = 1'b0; fflags_valid = 1'b0; fflags_in = 5'h0;
        trap_req = 1'b0; trap_pc = 32'h0; trap_cause = 32'h0; mret = 1'b0;
    endtask

    task automatic see(input string name, input logic [31:0] exp);
        @(negedge clk);
        chk(name, csr_rdata, exp);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout @%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin : stim
        #12;
        chk("rst_rdata", csr_rdata, 32'h0);
        chk("rst_illegal", {31'd0, csr_illegal}, 32'h0);
        chk("rst_frm", {29'd0, frm_out}, 32'h0);
        chk("rst_mtvec", mtvec_out, 32'h0);
        chk("rst_mepc", mepc_out, 32'h0);
        #11 rst_n = 1'b1;

        drive(1, 3'b001, 12'h340, 32'hDEAD_BEEF, 1); see("rw_old", 32'h0);
        drive(1, 3'b010, 12'h340, 32'h0, 0);         see("rs_nowrite", 32'hDEAD_BEEF);
        drive(1, 3'b011, 12'h340, 32'h0000_00FF, 1); see("rc_old", 32'hDEAD_BEEF);
        drive(1, 3'b010, 12'h340, 32'h0, 0);         see("rc_new", 32'hDEAD_BE00);
        drive(1, 3'b110, 12'h300, 32'h8, 1);         see("rsi_old", 32'h0);
        drive(1, 3'b010, 12'h300, 32'h0, 0);         see("mie_set", 32'h8);

        drive(0, 3'b000, 12'h000, 32'h0, 0); fflags_valid = 1; fflags_in = 5'b00001;
        drive(0, 3'b000, 12'h000, 32'h0, 0); fflags_valid = 1; fflags_in = 5'b10000;
        drive(1, 3'b010, 12'h001, 32'h0, 0);         see("fflags_acc", 32'h11);
        drive(1, 3'b001, 12'h003, 32'h40, 1); fflags_valid = 1; fflags_in = 5'h1F;
        see("fcsr_old", 32'h11);
        drive(1, 3'b010, 12'h003, 32'h0, 0);         see("fcsr_new", 32'h40);
        chk("frm_out", {29'd0, frm_out}, 32'h2);

        drive(1, 3'b001, 12'h305, 32'h0000_1003, 1);
        drive(0, 3'b000, 12'h000, 32'h0, 0);
        @(negedge clk); chk("mtvec_align", mtvec_out, 32'h0000_1000);

        drive(1, 3'b001, 12'hB00, 32'hFFFF_FFFF, 1);
        drive(1, 3'b001, 12'hB80, 32'hFFFF_FFFF, 1);
        drive(1, 3'b010, 12'hC00, 32'h0, 0);         see("cyc_no_inc", 32'hFFFF_FFFF);
        drive(1, 3'b010, 12'hC00, 32'h0, 0);         see("cyc_wrap_lo", 32'h0);
        drive(1, 3'b010, 12'hC80, 32'h0, 0);         see("cyc_wrap_hi", 32'h0);
        drive(1, 3'b001, 12'hC00, 32'h1, 1);
        @(negedge clk); chk("ro_write_illegal", {31'd0, csr_illegal}, 32'h1);
        drive(1, 3'b010, 12'hC00, 32'h0, 0);         see("ro_read_count", 32'h3);
        chk("ro_read_legal", {31'd0, csr_illegal}, 32'h0);
        drive(1, 3'b001, 12'h7FF, 32'h0, 1);
        @(negedge clk); chk("unmapped_illegal", {31'd0, csr_illegal}, 32'h1);
        drive(1, 3'b000, 12'h340, 32'h0, 0);
        @(negedge clk); chk("op000_illegal", {31'd0, csr_illegal}, 32'h1);

        for (int i = 0; i < 3; i++) begin
            drive(0, 3'b000, 12'h000, 32'h0, 0); instr_ret = 1;
        end
        drive(1, 3'b010, 12'hC02, 32'h0, 0);         see("instret", 32'h3);

        drive(1, 3'b001, 12'h340, 32'h1234_5678, 1);
        trap_req = 1; trap_pc = 32'h0000_1236; trap_cause = 32'h0000_000B;
        see("trap_rw_old", 32'hDEAD_BE00);
        drive(1, 3'b010, 12'h342, 32'h0, 0);         see("mcause", 32'hB);
        chk("mepc_out", mepc_out, 32'h0000_1234);
        drive(1, 3'b010, 12'h300, 32'h0, 0);         see("trap_mstatus", 32'h80);
        drive(1, 3'b010, 12'h340, 32'h0, 0);         see("mscratch_kept", 32'hDEAD_BE00);
        drive(0, 3'b000, 12'h000, 32'h0, 0); mret = 1;
        drive(1, 3'b010, 12'h300, 32'h0, 0);         see("mret_mstatus", 32'h88);

        drive(1, 3'b001, 12'h340, 32'h55, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_mepc", mepc_out, 32'h0);
        chk("midrst_mtvec", mtvec_out, 32'h0);
        chk("midrst_frm", {29'd0, frm_out}, 32'h0);
        csr_en = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        drive(1, 3'b010, 12'h340, 32'h0, 0);         see("midrst_mscratch", 32'h0);
        drive(1, 3'b010, 12'h300, 32'h0, 0);         see("midrst_mstatus", 32'h0);
        drive(0, 3'b000, 12'h000, 32'h0, 0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
